id_stage_pipe: RTL

Parametrised instruction-decode stage with an integrated multi-port register file, registered valid/ready output, write-back bypass and load-use bubble insertion. It sits between fetch and execute. It accepts one instruction per cycle, splits it into opcode, destination, two sources and an immediate, and presents three register operands plus the immediate to execute. Write-back arrives on a dedicated address/data port, independent of the instruction being decoded.

---
 rtl/id_stage_pipe.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage: field split, register file with write-back bypass,
// registered valid/ready output and load-use bubble insertion.
module id_stage_pipe #(
  parameter int ARQ  = 16,
  parameter int NREG = 4,
  parameter int OPW  = 4,
  parameter int IMMW = 10,
  parameter logic [OPW-1:0] LDOP = 4'b0010,
  localparam int REGW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ARQ-1:0]  instr,
  input  logic            wb_en,
  input  logic [REGW-1:0] wb_addr,
  input  logic [ARQ-1:0]  wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [REGW-1:0] out_rd,
  output logic [ARQ-1:0]  out_d,
  output logic [ARQ-1:0]  out_a,
  output logic [ARQ-1:0]  out_b,
  output logic [ARQ-1:0]  out_imm,
  output logic [15:0]     bubble_cnt
);

  logic [ARQ-1:0]  rf_q [NREG];

  logic [OPW-1:0]  op_w;
  logic [REGW-1:0] rd_w;
  logic [REGW-1:0] rs1_w;
  logic [REGW-1:0] rs2_w;
  logic [ARQ-1:0]  imm_w;

  logic [ARQ-1:0]  rdv_w;
  logic [ARQ-1:0]  r1v_w;
  logic [ARQ-1:0]  r2v_w;

  logic            vld_q, vld_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [REGW-1:0] rs1_q, rs1_d;
  logic [REGW-1:0] rs2_q, rs2_d;
  logic [ARQ-1:0]  dv_q, dv_d;
  logic [ARQ-1:0]  av_q, av_d;
  logic [ARQ-1:0]  bv_q, bv_d;
  logic [ARQ-1:0]  imm_q, imm_d;
  logic            ldp_q, ldp_d;
  logic [REGW-1:0] ldrd_q, ldrd_d;
  logic [15:0]     bcnt_q, bcnt_d;

  logic            free;
  logic            hazard;

  // Field split and operand read with same-cycle write-back bypass
  always_comb begin
    op_w  = instr[ARQ-1 -: OPW];
    rd_w  = instr[ARQ-OPW-1 -: REGW];
    rs1_w = instr[ARQ-OPW-REGW-1 -: REGW];
    rs2_w = instr[ARQ-OPW-2*REGW-1 -: REGW];
    imm_w = ARQ'(instr[IMMW-1:0]);
    rdv_w = (wb_en && wb_addr == rd_w)  ? wb_data : rf_q[rd_w];
    r1v_w = (wb_en && wb_addr == rs1_w) ? wb_data : rf_q[rs1_w];
    r2v_w = (wb_en && wb_addr == rs2_w) ? wb_data : rf_q[rs2_w];
  end

  // Register file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Next-state: bubble, capture, drain or hold with operand refresh
  always_comb begin
    free     = !vld_q || out_ready;
    hazard   = in_valid && ldp_q &&
               (rs1_w == ldrd_q || rs2_w == ldrd_q);
    in_ready = free && !hazard;
    vld_d  = vld_q;
    op_d   = op_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    dv_d   = dv_q;
    av_d   = av_q;
    bv_d   = bv_q;
    imm_d  = imm_q;
    ldp_d  = ldp_q;
    ldrd_d = ldrd_q;
    bcnt_d = bcnt_q;
    if (free && hazard) begin
      vld_d  = 1'b0;
      ldp_d  = 1'b0;
      bcnt_d = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
    end else if (free && in_valid) begin
      vld_d  = 1'b1;
      op_d   = op_w;
      rd_d   = rd_w;
      rs1_d  = rs1_w;
      rs2_d  = rs2_w;
      dv_d   = rdv_w;
      av_d   = r1v_w;
      bv_d   = r2v_w;
      imm_d  = imm_w;
      ldp_d  = (op_w == LDOP);
      ldrd_d = rd_w;
    end else if (free) begin
      vld_d = 1'b0;
      ldp_d = 1'b0;
    end else if (wb_en) begin
      if (wb_addr == rd_q)  dv_d = wb_data;
      if (wb_addr == rs1_q) av_d = wb_data;
      if (wb_addr == rs2_q) bv_d = wb_data;
    end
  end

  // Pipeline and hazard state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      dv_q   <= '0;
      av_q   <= '0;
      bv_q   <= '0;
      imm_q  <= '0;
      ldp_q  <= 1'b0;
      ldrd_q <= '0;
      bcnt_q <= '0;
    end else begin
      vld_q  <= vld_d;
      op_q   <= op_d;
      rd_q   <= rd_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      dv_q   <= dv_d;
      av_q   <= av_d;
      bv_q   <= bv_d;
      imm_q  <= imm_d;
      ldp_q  <= ldp_d;
      ldrd_q <= ldrd_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_op     = op_q;
  assign out_rd     = rd_q;
  assign out_d      = dv_q;
  assign out_a      = av_q;
  assign out_b      = bv_q;
  assign out_imm    = imm_q;
  assign bubble_cnt = bcnt_q;

endmodule
